// File: rtl/decode_pkg.sv
// Shared types, opcode and control encodings for the registered decode stage.
`ifndef IMM_TYPE_BITS
`define IMM_TYPE_BITS 3
`endif
`ifndef ALU_OP_BITS
`define ALU_OP_BITS 3
`endif
`ifndef BRANCH_TYPE_BITS
`define BRANCH_TYPE_BITS 4
`endif
`ifndef RESULT_SRC_BITS
`define RESULT_SRC_BITS 2
`endif

package decode_pkg;

  localparam int PC_MAX_W = 64;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_COND_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [`IMM_TYPE_BITS-1:0] IMM_I = 3'd0;
  localparam logic [`IMM_TYPE_BITS-1:0] IMM_S = 3'd1;
  localparam logic [`IMM_TYPE_BITS-1:0] IMM_B = 3'd2;
  localparam logic [`IMM_TYPE_BITS-1:0] IMM_U = 3'd3;
  localparam logic [`IMM_TYPE_BITS-1:0] IMM_J = 3'd4;

  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;

  localparam logic SRC2_RS2 = 1'b0;
  localparam logic SRC2_IMM = 1'b1;

  localparam logic [`ALU_OP_BITS-1:0] ALU_ADD      = 3'd0;
  localparam logic [`ALU_OP_BITS-1:0] ALU_BRANCH   = 3'd1;
  localparam logic [`ALU_OP_BITS-1:0] ALU_OP       = 3'd2;
  localparam logic [`ALU_OP_BITS-1:0] ALU_OPIMM    = 3'd3;
  localparam logic [`ALU_OP_BITS-1:0] ALU_OP32     = 3'd4;
  localparam logic [`ALU_OP_BITS-1:0] ALU_OPIMM32  = 3'd5;

  // Conditional branches use {funct3,1'b1}; jumps use even codes
  localparam logic [`BRANCH_TYPE_BITS-1:0] NOT_BRANCH = 4'b0000;
  localparam logic [`BRANCH_TYPE_BITS-1:0] BR_JAL     = 4'b0010;
  localparam logic [`BRANCH_TYPE_BITS-1:0] BR_JALR    = 4'b0100;

  localparam logic [`RESULT_SRC_BITS-1:0] RES_ALU = 2'd0;
  localparam logic [`RESULT_SRC_BITS-1:0] RES_MEM = 2'd1;
  localparam logic [`RESULT_SRC_BITS-1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic [`IMM_TYPE_BITS-1:0]    imm_type;
    logic [1:0]                   alu_src1;
    logic                         alu_src2;
    logic [`ALU_OP_BITS-1:0]      alu_op;
    logic [`BRANCH_TYPE_BITS-1:0] branch_type;
    logic                         we_memory;
    logic                         we_gpr;
    logic [`RESULT_SRC_BITS-1:0]  result_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{imm_type: IMM_I, alu_src1: SRC1_RS1, alu_src2: SRC2_RS2,
                                 alu_op: ALU_ADD, branch_type: NOT_BRANCH, we_memory: 1'b0,
                                 we_gpr: 1'b0, result_src: RES_ALU};

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [31:0]         instr;
    ctrl_t               ctrl;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                illegal;
  } decode_entry_t;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} main_state_e;

  function automatic ctrl_t make_ctrl(
    input logic [`IMM_TYPE_BITS-1:0]    imm_type,
    input logic [1:0]                   alu_src1,
    input logic                         alu_src2,
    input logic [`ALU_OP_BITS-1:0]      alu_op,
    input logic [`BRANCH_TYPE_BITS-1:0] branch_type,
    input logic                         we_memory,
    input logic                         we_gpr,
    input logic [`RESULT_SRC_BITS-1:0]  result_src
  );
    ctrl_t c;
    c.imm_type    = imm_type;
    c.alu_src1    = alu_src1;
    c.alu_src2    = alu_src2;
    c.alu_op      = alu_op;
    c.branch_type = branch_type;
    c.we_memory   = we_memory;
    c.we_gpr      = we_gpr;
    c.result_src  = result_src;
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_ctrl.sv
// Combinational instruction -> control bundle decoder with illegal detection.
// RV64-only opcodes are rejected when XLEN < 64.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  ctrl_t      raw_ctrl_s;
  logic       raw_illegal_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];

  // Per-opcode control table; anything not listed is illegal
  always_comb begin
    raw_ctrl_s    = CTRL_NOP;
    raw_illegal_s = 1'b0;
    case (opcode_s)
      OPC_LUI:   raw_ctrl_s = make_ctrl(IMM_U, SRC1_ZERO, SRC2_IMM, ALU_ADD, NOT_BRANCH, 1'b0, 1'b1, RES_ALU);
      OPC_AUIPC: raw_ctrl_s = make_ctrl(IMM_U, SRC1_PC, SRC2_IMM, ALU_ADD, NOT_BRANCH, 1'b0, 1'b1, RES_ALU);
      OPC_JAL:   raw_ctrl_s = make_ctrl(IMM_J, SRC1_PC, SRC2_IMM, ALU_ADD, BR_JAL, 1'b0, 1'b1, RES_PC4);
      OPC_JALR: begin
        if (funct3_s != 3'b000) begin
          raw_illegal_s = 1'b1;
        end else begin
          raw_ctrl_s = make_ctrl(IMM_I, SRC1_RS1, SRC2_IMM, ALU_ADD, BR_JALR, 1'b0, 1'b1, RES_PC4);
        end
      end
      OPC_COND_BR: begin
        if (funct3_s == 3'b010 || funct3_s == 3'b011) begin
          raw_illegal_s = 1'b1;
        end else begin
          raw_ctrl_s = make_ctrl(IMM_B, SRC1_RS1, SRC2_RS2, ALU_BRANCH, {funct3_s, 1'b1}, 1'b0, 1'b0, RES_ALU);
        end
      end
      OPC_LOAD:   raw_ctrl_s = make_ctrl(IMM_I, SRC1_RS1, SRC2_IMM, ALU_ADD, NOT_BRANCH, 1'b0, 1'b1, RES_MEM);
      OPC_STORE:  raw_ctrl_s = make_ctrl(IMM_S, SRC1_RS1, SRC2_IMM, ALU_ADD, NOT_BRANCH, 1'b1, 1'b0, RES_ALU);
      OPC_OP_IMM: raw_ctrl_s = make_ctrl(IMM_I, SRC1_RS1, SRC2_IMM, ALU_OPIMM, NOT_BRANCH, 1'b0, 1'b1, RES_ALU);
      OPC_OP:     raw_ctrl_s = make_ctrl(IMM_I, SRC1_RS1, SRC2_RS2, ALU_OP, NOT_BRANCH, 1'b0, 1'b1, RES_ALU);
      OPC_OP_IMM_32: begin
        if (XLEN < 64) begin
          raw_illegal_s = 1'b1;
        end else begin
          raw_ctrl_s = make_ctrl(IMM_I, SRC1_RS1, SRC2_IMM, ALU_OPIMM32, NOT_BRANCH, 1'b0, 1'b1, RES_ALU);
        end
      end
      OPC_OP_32: begin
        if (XLEN < 64) begin
          raw_illegal_s = 1'b1;
        end else begin
          raw_ctrl_s = make_ctrl(IMM_I, SRC1_RS1, SRC2_RS2, ALU_OP32, NOT_BRANCH, 1'b0, 1'b1, RES_ALU);
        end
      end
      default: raw_illegal_s = 1'b1;
    endcase
  end

  // Illegal entries carry a NOP bundle so nothing downstream writes state
  assign illegal = raw_illegal_s || (instr[1:0] != 2'b11);
  assign ctrl    = illegal ? CTRL_NOP : raw_ctrl_s;

endmodule

// File: rtl/decode_stage.sv
// Registered valid/ready decode stage with flush.
// Optional one-entry skid buffer (registered in_ready) enabled by DECODE_SKID_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output ctrl_t           out_ctrl,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_illegal
);

  main_state_e   state_r;
  main_state_e   state_next_s;
  decode_entry_t main_r;
  decode_entry_t new_entry_s;
  decode_entry_t skid_entry_s;
  ctrl_t         dec_ctrl_s;
  logic          dec_illegal_s;
  logic          skid_valid_s;
  logic          accept_s;
  logic          load_main_s;
  logic          skid_to_main_s;

  decode_ctrl #(.XLEN(XLEN)) u_decode_ctrl (
    .instr   (in_instr),
    .ctrl    (dec_ctrl_s),
    .illegal (dec_illegal_s)
  );

  // Pack the freshly decoded instruction into a pipeline entry
  always_comb begin
    new_entry_s         = '0;
    new_entry_s.pc      = PC_MAX_W'(in_pc);
    new_entry_s.instr   = in_instr;
    new_entry_s.ctrl    = dec_ctrl_s;
    new_entry_s.rd      = in_instr[11:7];
    new_entry_s.rs1     = in_instr[19:15];
    new_entry_s.rs2     = in_instr[24:20];
    new_entry_s.illegal = dec_illegal_s;
  end

`ifdef DECODE_SKID_EN
  decode_entry_t skid_r;
  logic          skid_valid_r;

  assign skid_valid_s = skid_valid_r;
  assign skid_entry_s = skid_r;
  assign in_ready     = ~skid_valid_r;

  // Skid catches the one input accepted while main is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_r <= 1'b0;
      skid_r       <= '0;
    end else if (flush || skid_to_main_s) begin
      skid_valid_r <= 1'b0;
      skid_r       <= skid_r;
    end else if (state_r == ST_FULL && !out_ready && accept_s) begin
      skid_valid_r <= 1'b1;
      skid_r       <= new_entry_s;
    end else begin
      skid_valid_r <= skid_valid_r;
      skid_r       <= skid_r;
    end
  end
`else
  assign skid_valid_s = 1'b0;
  assign skid_entry_s = '0;
  assign in_ready     = (state_r == ST_EMPTY) || out_ready;
`endif

  assign accept_s = in_valid && in_ready;

  // Main register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next main-register state; flush overrides every handshake
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = accept_s ? ST_FULL : ST_EMPTY;
        ST_FULL: begin
          if (out_ready) begin
            state_next_s = (accept_s || skid_valid_s) ? ST_FULL : ST_EMPTY;
          end else begin
            state_next_s = ST_FULL;
          end
        end
        default: state_next_s = ST_EMPTY;
      endcase
    end
  end

  // Main-register load strobes; an older skid entry always wins over new input
  always_comb begin
    load_main_s    = 1'b0;
    skid_to_main_s = 1'b0;
    if (flush) begin
      load_main_s    = 1'b0;
      skid_to_main_s = 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: load_main_s = accept_s;
        ST_FULL: begin
          if (out_ready) begin
            skid_to_main_s = skid_valid_s;
            load_main_s    = accept_s && !skid_valid_s;
          end else begin
            load_main_s    = 1'b0;
          end
        end
        default: load_main_s = 1'b0;
      endcase
    end
  end

  // Main payload register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r <= '0;
    end else if (load_main_s) begin
      main_r <= new_entry_s;
    end else if (skid_to_main_s) begin
      main_r <= skid_entry_s;
    end else begin
      main_r <= main_r;
    end
  end

  assign out_valid   = (state_r == ST_FULL);
  assign out_pc      = main_r.pc[PC_W-1:0];
  assign out_instr   = main_r.instr;
  assign out_ctrl    = main_r.ctrl;
  assign out_rd      = main_r.rd;
  assign out_rs1     = main_r.rs1;
  assign out_rs2     = main_r.rs2;
  assign out_illegal = main_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=64 and XLEN=32 instances).
// Expectations follow DECODE_SKID_EN when it is defined for the build.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [63:0] in_pc = 64'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  ctrl_t       out_ctrl;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] in_pc32, out_pc32, out_instr32;
  ctrl_t       out_ctrl32;
  logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DECODE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  assign in_pc32 = in_pc[31:0];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_ctrl(out_ctrl), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_pc(out_pc32), .out_instr(out_instr32), .out_ctrl(out_ctrl32), .out_rd(out_rd32),
    .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_illegal(out_illegal32)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ctrl_t mk(input logic [2:0] it, input logic [1:0] s1, input logic s2,
                               input logic [2:0] op, input logic [3:0] br, input logic wm,
                               input logic wg, input logic [1:0] rs);
    ctrl_t c;
    c.imm_type = it; c.alu_src1 = s1; c.alu_src2 = s2; c.alu_op = op;
    c.branch_type = br; c.we_memory = wm; c.we_gpr = wg; c.result_src = rs;
    return c;
  endfunction

  localparam int NV = 15;
  logic [31:0] v_instr [NV];
  ctrl_t       v_ctrl  [NV];
  logic        v_ill   [NV];
  logic        v_ill32 [NV];
  logic [31:0] stream  [4];
  ctrl_t       nop_c;
  ctrl_t       exp_c;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, seen;
    logic acc, xfer;
    nop_c = mk(3'd0, 2'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 2'd0);

    v_instr[0]  = 32'h00500093; v_ctrl[0]  = mk(3'd0, 2'd0, 1'b1, 3'd3, 4'b0000, 1'b0, 1'b1, 2'd0); // addi x1,x0,5
    v_instr[1]  = 32'h0000001B; v_ctrl[1]  = mk(3'd0, 2'd0, 1'b1, 3'd5, 4'b0000, 1'b0, 1'b1, 2'd0); // addiw
    v_instr[2]  = 32'h00208463; v_ctrl[2]  = mk(3'd2, 2'd0, 1'b0, 3'd1, 4'b0001, 1'b0, 1'b0, 2'd0); // beq
    v_instr[3]  = 32'h0020A463; v_ctrl[3]  = nop_c;                                              // funct3=010
    v_instr[4]  = 32'h123452B7; v_ctrl[4]  = mk(3'd3, 2'd2, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b1, 2'd0); // lui x5
    v_instr[5]  = 32'h00000097; v_ctrl[5]  = mk(3'd3, 2'd1, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b1, 2'd0); // auipc x1
    v_instr[6]  = 32'h000000EF; v_ctrl[6]  = mk(3'd4, 2'd1, 1'b1, 3'd0, 4'b0010, 1'b0, 1'b1, 2'd2); // jal x1
    v_instr[7]  = 32'h000100E7; v_ctrl[7]  = mk(3'd0, 2'd0, 1'b1, 3'd0, 4'b0100, 1'b0, 1'b1, 2'd2); // jalr x1,0(x2)
    v_instr[8]  = 32'h000110E7; v_ctrl[8]  = nop_c;                                              // jalr funct3=1
    v_instr[9]  = 32'h0000A103; v_ctrl[9]  = mk(3'd0, 2'd0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b1, 2'd1); // lw x2,0(x1)
    v_instr[10] = 32'h00112023; v_ctrl[10] = mk(3'd1, 2'd0, 1'b1, 3'd0, 4'b0000, 1'b1, 1'b0, 2'd0); // sw x1,0(x2)
    v_instr[11] = 32'h002081B3; v_ctrl[11] = mk(3'd0, 2'd0, 1'b0, 3'd2, 4'b0000, 1'b0, 1'b1, 2'd0); // add x3,x1,x2
    v_instr[12] = 32'h002081BB; v_ctrl[12] = mk(3'd0, 2'd0, 1'b0, 3'd4, 4'b0000, 1'b0, 1'b1, 2'd0); // addw
    v_instr[13] = 32'h00000001; v_ctrl[13] = nop_c;                                              // compressed
    v_instr[14] = 32'h0000007F; v_ctrl[14] = nop_c;                                              // unknown opcode
    for (int i = 0; i < NV; i++) begin
      v_ill[i]   = (i == 3 || i == 8 || i == 13 || i == 14);
      v_ill32[i] = v_ill[i] || (i == 1 || i == 12);
    end

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_regs", 64'({out_rd, out_rs1, out_rs2}), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed decode table, streamed back to back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = v_instr[i];
      in_pc    = 64'h1000 + 64'(i * 4);
      tick();
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_ctrl", i), 64'(out_ctrl), 64'(v_ctrl[i]));
      check($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(v_ill[i]));
      check($sformatf("v%0d_pc", i), out_pc, 64'h1000 + 64'(i * 4));
      check($sformatf("v%0d_regs", i), 64'({out_rd, out_rs1, out_rs2}),
            64'({v_instr[i][11:7], v_instr[i][19:15], v_instr[i][24:20]}));
      exp_c = v_ill32[i] ? nop_c : v_ctrl[i];
      check($sformatf("v%0d_ctrl32", i), 64'(out_ctrl32), 64'(exp_c));
      check($sformatf("v%0d_illegal32", i), 64'(out_illegal32), 64'(v_ill32[i]));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Back-pressure: 4 instructions offered, out_ready low for 3 cycles
    for (int k = 0; k < 4; k++) stream[k] = 32'h00000013 | (32'(k + 1) << 20) | (32'(k + 1) << 7);
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      in_valid  = (sent < 4);
      in_instr  = stream[(sent < 4) ? sent : 3];
      out_ready = (cyc >= 3);
      #1;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (cyc == 0) check("bp_empty", 64'(out_valid), 64'd0);
      if (cyc == 1) check("bp_in_ready_c1", 64'(in_ready), 64'(SKID));
      if (cyc == 1 || cyc == 2) begin
        check($sformatf("bp_stall_valid_c%0d", cyc), 64'(out_valid), 64'd1);
        check($sformatf("bp_stall_instr_c%0d", cyc), 64'(out_instr), 64'(stream[0]));
      end
      if (cyc == 2) check("bp_in_ready_c2", 64'(in_ready), 64'd0);
      if (cyc == 3) check("bp_accepted", 64'(sent), SKID ? 64'd2 : 64'd1);
      if (xfer) begin
        check($sformatf("bp_order_%0d", recv), 64'(out_instr), 64'(stream[recv]));
        recv++;
      end
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    check("bp_received", 64'(recv), 64'd4);
    in_valid = 1'b0;
    #1;
    check("bp_final_empty", 64'(out_valid), 64'd0);

    // Flush while full (and skid full when present) with an input offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00700393;
    tick();
    in_instr  = 32'h00800413;
    tick();
    check("fl_pre_instr", 64'(out_instr), 64'h00700393);
    flush     = 1'b1;
    in_instr  = 32'h7FF00493;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    // Flush from empty: the input is accepted but must be discarded
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h7FE00513;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    seen     = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) seen++;
      tick();
    end
    check("fl_nothing_emerges", 64'(seen), 64'd0);

    // Asynchronous reset between edges while holding an illegal entry
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    check("ar_pre_illegal", 64'(out_illegal), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_illegal", 64'(out_illegal), 64'd0);
    check("ar_instr", 64'(out_instr), 64'd0);
    check("ar_ctrl", 64'(out_ctrl), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    in_pc     = 64'h2000;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_ctrl", 64'(out_ctrl), 64'(v_ctrl[0]));
    check("post_rst_rd", 64'(out_rd), 64'd1);
    check("post_rst_pc", out_pc, 64'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
